// File: rtl/matmul_ctrl_pkg.sv
// Shared command and state encodings for the matmul host-side controller.
package matmul_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_LOAD_A = 2'b00,
        OP_LOAD_B = 2'b01,
        OP_RUN    = 2'b10,
        OP_READ_C = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_LOAD_DRAIN = 3'd2,
        ST_RUN        = 3'd3,
        ST_READ       = 3'd4,
        ST_READ_DRAIN = 3'd5
    } ctrl_state_e;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift pipe carrying a valid vector alongside a data word.
module valid_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned VW    = 1,
    parameter int unsigned DW    = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [VW-1:0] in_valid,
    input  logic [DW-1:0] in_data,
    output logic [VW-1:0] out_valid,
    output logic [DW-1:0] out_data
);

    logic [VW-1:0] valid_q [DEPTH];
    logic [DW-1:0] data_q  [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/matmul_host_ctrl.sv
// Host command sequencer for the matmul array: loads A/B rows into BRAM,
// kicks a multiply run with a timeout, and streams C rows back out.
module matmul_host_ctrl
    import matmul_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH       = 7,
    parameter int unsigned DWIDTH       = 8,
    parameter int unsigned MAT_MUL_SIZE = 16,
    parameter int unsigned NUM_ROWS     = 32,
    parameter int unsigned WR_ALIGN     = 2,
    parameter int unsigned RD_LAT       = 4,
    parameter int unsigned RUN_TIMEOUT  = 1023
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    input  logic [1:0]                     cmd_op,
    output logic                           cmd_ready,
    input  logic                           wr_valid,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] wr_data,
    output logic                           wr_ready,
    output logic                           rd_valid,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] rd_data,
    output logic                           busy,
    output logic                           err_timeout,
    output logic                           enable_writing_to_mem,
    output logic                           enable_reading_from_mem,
    output logic                           we_a,
    output logic                           we_b,
    output logic                           we_c,
    output logic                           start_mat_mul,
    output logic [AWIDTH-1:0]              addr_pi,
    output logic [MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
    input  logic                           done_mat_mul,
    input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat
);

    localparam int unsigned DW  = MAT_MUL_SIZE * DWIDTH;
    localparam int unsigned RW  = $clog2(NUM_ROWS + 1);
    localparam int unsigned TW  = $clog2(RUN_TIMEOUT + 1);
    localparam int unsigned DRW = $clog2(WR_ALIGN + 1);

    ctrl_state_e    state;
    cmd_op_e        op_q;
    logic [RW-1:0]  row_cnt;
    logic [TW-1:0]  run_cnt;
    logic [DRW-1:0] drain_cnt;
    logic [1:0]     wr_iss;
    logic [DW-1:0]  wr_data_q;
    logic           rd_iss;
    logic           rd_last_in;
    logic           rd_last;
    logic [1:0]     wr_we;
    logic           beat;

    assign beat       = wr_valid & wr_ready;
    assign rd_last_in = (addr_pi == AWIDTH'(NUM_ROWS - 1));

    // Outputs are registered and set for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                   <= ST_IDLE;
            op_q                    <= OP_LOAD_A;
            row_cnt                 <= '0;
            run_cnt                 <= '0;
            drain_cnt               <= '0;
            wr_iss                  <= '0;
            wr_data_q               <= '0;
            rd_iss                  <= 1'b0;
            addr_pi                 <= '0;
            cmd_ready               <= 1'b1;
            busy                    <= 1'b0;
            wr_ready                <= 1'b0;
            enable_writing_to_mem   <= 1'b0;
            enable_reading_from_mem <= 1'b0;
            start_mat_mul           <= 1'b0;
            we_c                    <= 1'b0;
            err_timeout             <= 1'b0;
        end else begin
            wr_iss <= '0;
            rd_iss <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op_e'(cmd_op);
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        row_cnt   <= '0;
                        run_cnt   <= '0;
                        drain_cnt <= '0;
                        case (cmd_op_e'(cmd_op))
                            OP_LOAD_A, OP_LOAD_B: begin
                                state                 <= ST_LOAD;
                                enable_writing_to_mem <= 1'b1;
                                wr_ready              <= 1'b1;
                            end
                            OP_RUN: begin
                                state         <= ST_RUN;
                                start_mat_mul <= 1'b1;
                                we_c          <= 1'b1;
                            end
                            default: begin
                                state                   <= ST_READ;
                                enable_reading_from_mem <= 1'b1;
                                addr_pi                 <= '0;
                                rd_iss                  <= 1'b1;
                                row_cnt                 <= RW'(1);
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        addr_pi   <= AWIDTH'(row_cnt);
                        wr_iss    <= (op_q == OP_LOAD_B) ? 2'b10 : 2'b01;
                        wr_data_q <= wr_data;
                        if (row_cnt == RW'(NUM_ROWS - 1)) begin
                            state    <= ST_LOAD_DRAIN;
                            wr_ready <= 1'b0;
                        end else begin
                            row_cnt <= row_cnt + RW'(1);
                        end
                    end
                end
                // Keep the write enable up until the last aligned we has gone out.
                ST_LOAD_DRAIN: begin
                    if (drain_cnt == DRW'(WR_ALIGN)) begin
                        state                 <= ST_IDLE;
                        enable_writing_to_mem <= 1'b0;
                        busy                  <= 1'b0;
                        cmd_ready             <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRW'(1);
                    end
                end
                ST_RUN: begin
                    if (done_mat_mul || (run_cnt == TW'(RUN_TIMEOUT - 1))) begin
                        state         <= ST_IDLE;
                        start_mat_mul <= 1'b0;
                        we_c          <= 1'b0;
                        busy          <= 1'b0;
                        cmd_ready     <= 1'b1;
                        if (!done_mat_mul) begin
                            err_timeout <= 1'b1;
                        end
                    end else begin
                        run_cnt <= run_cnt + TW'(1);
                    end
                end
                ST_READ: begin
                    if (row_cnt == RW'(NUM_ROWS)) begin
                        state <= ST_READ_DRAIN;
                    end else begin
                        addr_pi <= AWIDTH'(row_cnt);
                        rd_iss  <= 1'b1;
                        row_cnt <= row_cnt + RW'(1);
                    end
                end
                ST_READ_DRAIN: begin
                    if (rd_valid && rd_last) begin
                        state                   <= ST_IDLE;
                        enable_reading_from_mem <= 1'b0;
                        busy                    <= 1'b0;
                        cmd_ready               <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Write beats land on the BRAM port WR_ALIGN cycles after their address.
    valid_delay_line #(
        .DEPTH (WR_ALIGN),
        .VW    (2),
        .DW    (DW)
    ) u_wr_dly (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (wr_iss),
        .in_data   (wr_data_q),
        .out_valid (wr_we),
        .out_data  (data_pi)
    );

    assign we_a = wr_we[0];
    assign we_b = wr_we[1];

    // Read returns line up with the memory's RD_LAT; the data bit marks the final row.
    valid_delay_line #(
        .DEPTH (RD_LAT),
        .VW    (1),
        .DW    (1)
    ) u_rd_dly (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_iss),
        .in_data   (rd_last_in),
        .out_valid (rd_valid),
        .out_data  (rd_last)
    );

    assign rd_data = rd_valid ? data_from_out_mat : '0;

endmodule

// File: tb/tb_matmul_host_ctrl.sv
// Self-checking bench for matmul_host_ctrl: table-driven loads and runs,
// randomized write gaps and read data, plus reset/back-to-back sequences.
module tb_matmul_host_ctrl;

    localparam int AW  = 7;
    localparam int NR  = 32;
    localparam int WA  = 2;
    localparam int RL  = 4;
    localparam int RTO = 1023;
    localparam int W   = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic          cmd_ready;
    logic          wr_valid;
    logic [W-1:0]  wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [W-1:0]  rd_data;
    logic          busy;
    logic          err_timeout;
    logic          enable_writing_to_mem;
    logic          enable_reading_from_mem;
    logic          we_a;
    logic          we_b;
    logic          we_c;
    logic          start_mat_mul;
    logic [AW-1:0] addr_pi;
    logic [W-1:0]  data_pi;
    logic          done_mat_mul;
    logic [W-1:0]  data_from_out_mat;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] salt;
    logic [RL*AW-1:0] addr_hist;

    always #5 clk = ~clk;

    matmul_host_ctrl dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_op                  (cmd_op),
        .cmd_ready               (cmd_ready),
        .wr_valid                (wr_valid),
        .wr_data                 (wr_data),
        .wr_ready                (wr_ready),
        .rd_valid                (rd_valid),
        .rd_data                 (rd_data),
        .busy                    (busy),
        .err_timeout             (err_timeout),
        .enable_writing_to_mem   (enable_writing_to_mem),
        .enable_reading_from_mem (enable_reading_from_mem),
        .we_a                    (we_a),
        .we_b                    (we_b),
        .we_c                    (we_c),
        .start_mat_mul           (start_mat_mul),
        .addr_pi                 (addr_pi),
        .data_pi                 (data_pi),
        .done_mat_mul            (done_mat_mul),
        .data_from_out_mat       (data_from_out_mat)
    );

    // Output-matrix memory model: contents are a keyed hash of the row address.
    function automatic logic [W-1:0] mem_f(input logic [AW-1:0] a, input logic [31:0] s);
        logic [31:0] x;
        x = ((32'(a) + 32'd1) * 32'h9E3779B1) ^ s;
        return {x, ~x, x ^ 32'h5A5A5A5A, x + s};
    endfunction

    always @(posedge clk) addr_hist <= {addr_hist[(RL-1)*AW-1:0], addr_pi};
    assign data_from_out_mat = mem_f(addr_hist[RL*AW-1 -: AW], salt);

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkd(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first cycle of the new state.
    task automatic issue_cmd(input logic [1:0] op);
        chk1("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk1("cmd_ready_busy", cmd_ready, 1'b0);
        chk1("busy_active", busy, 1'b1);
    endtask

    // mode 0: continuous, wr_data = row index; 1: every other cycle; 2: random gaps/data.
    task automatic run_load(input bit is_b, input int mode, input int abort_beat, output int pulses);
        int due[$];
        logic [W-1:0] sent[$];
        int beats, addr_next, idle_at;
        bit v, exp_we, done_ok, sel;
        logic [W-1:0] d;
        beats = 0; addr_next = -1; idle_at = -1; pulses = 0; done_ok = 1'b0;
        issue_cmd(is_b ? 2'b01 : 2'b00);
        chk1("en_w_load", enable_writing_to_mem, 1'b1);
        for (int c = 0; c < 500; c++) begin
            exp_we = (due.size() != 0) && (due[0] == c);
            sel    = is_b ? we_b : we_a;
            chk1("we_target", sel, exp_we);
            chk1("we_other", is_b ? we_a : we_b, 1'b0);
            if (sel) pulses++;
            if (exp_we) begin
                chkd("data_pi", data_pi, sent[0]);
                chk1("en_w_at_we", enable_writing_to_mem, 1'b1);
                void'(due.pop_front());
                void'(sent.pop_front());
                if (beats == NR && due.size() == 0) idle_at = c + 1;
            end
            if (addr_next >= 0) begin
                chki("addr_pi_wr", int'(addr_pi), addr_next);
                addr_next = -1;
            end
            if (c == idle_at) begin
                chk1("load_idle_ready", cmd_ready, 1'b1);
                chk1("load_idle_en_w", enable_writing_to_mem, 1'b0);
                chk1("load_idle_busy", busy, 1'b0);
                done_ok = 1'b1;
                break;
            end
            chk1("wr_ready", wr_ready, beats < NR);
            if (abort_beat >= 0 && beats == abort_beat) begin
                reset = 1'b0;
                #1;
                chk1("rst_we_a", we_a, 1'b0);
                chk1("rst_en_w", enable_writing_to_mem, 1'b0);
                chk1("rst_wr_ready", wr_ready, 1'b0);
                chk1("rst_busy", busy, 1'b0);
                chki("rst_addr", int'(addr_pi), 0);
                chkd("rst_data_pi", data_pi, '0);
                wr_valid = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk1("rst_hold_we_a", we_a, 1'b0);
                end
                reset = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk1("post_rst_we_a", we_a, 1'b0);
                    chk1("post_rst_ready", cmd_ready, 1'b1);
                end
                done_ok = 1'b1;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (c % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = (mode == 0) ? W'(beats) : {$urandom, $urandom, $urandom, $urandom};
            if (beats == NR) begin
                v = 1'b1;
                d = '1;
            end
            wr_valid = v;
            wr_data  = d;
            if (v && beats < NR) begin
                due.push_back(c + 1 + WA);
                sent.push_back(d);
                addr_next = beats;
                beats++;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
        if (!done_ok) begin
            n_checks++;
            n_err++;
            $display("FAIL load_budget: load did not return to idle, beats=%0d", beats);
        end
    endtask

    // Starts at the negedge of the first READ cycle; ends at the negedge of the IDLE cycle.
    task automatic read_check();
        int beats;
        bit exp_v;
        beats = 0;
        for (int c = 0; c <= NR + RL; c++) begin
            if (c < NR) chki("addr_pi_rd", int'(addr_pi), c);
            exp_v = (c >= RL) && (c < NR + RL);
            chk1("rd_valid", rd_valid, exp_v);
            if (rd_valid) beats++;
            if (exp_v) chkd("rd_data", rd_data, mem_f(AW'(c - RL), salt));
            if (c < NR + RL) begin
                chk1("en_r_active", enable_reading_from_mem, 1'b1);
                @(negedge clk);
            end else begin
                chk1("read_idle_en_r", enable_reading_from_mem, 1'b0);
                chk1("read_idle_ready", cmd_ready, 1'b1);
                chk1("read_idle_busy", busy, 1'b0);
            end
        end
        chki("read_beats", beats, NR);
    endtask

    typedef struct {
        bit is_b;
        int mode;
        int exp_pulses;
    } load_vec_t;

    typedef struct {
        int done_at;
        int exp_drop;
        bit exp_err;
    } run_vec_t;

    load_vec_t lv[4];
    run_vec_t  rv[4];

    initial begin
        int pulses, drop;
        bit agree;

        lv[0] = '{1'b0, 0, NR};
        lv[1] = '{1'b1, 1, NR};
        lv[2] = '{1'b0, 2, NR};
        lv[3] = '{1'b1, 2, NR};
        rv[0] = '{100, 101, 1'b0};
        rv[1] = '{0, 1, 1'b0};
        rv[2] = '{7, 8, 1'b0};
        rv[3] = '{-1, RTO, 1'b1};

        reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00;
        wr_valid = 1'b0; wr_data = '0; done_mat_mul = 1'b0;
        salt = $urandom;
        repeat (3) @(negedge clk);
        chk1("rst0_we_a", we_a, 1'b0);
        chk1("rst0_we_b", we_b, 1'b0);
        chk1("rst0_we_c", we_c, 1'b0);
        chk1("rst0_start", start_mat_mul, 1'b0);
        chk1("rst0_rd_valid", rd_valid, 1'b0);
        chkd("rst0_rd_data", rd_data, '0);
        chk1("rst0_busy", busy, 1'b0);
        chk1("rst0_err", err_timeout, 1'b0);
        chk1("rst0_wr_ready", wr_ready, 1'b0);
        chki("rst0_addr", int'(addr_pi), 0);
        reset = 1'b1;
        @(negedge clk);
        chk1("rel_cmd_ready", cmd_ready, 1'b1);
        chk1("rel_busy", busy, 1'b0);

        foreach (lv[i]) begin
            run_load(lv[i].is_b, lv[i].mode, -1, pulses);
            chki("load_pulses", pulses, lv[i].exp_pulses);
        end

        salt = $urandom;
        issue_cmd(2'b11);
        read_check();

        // RUN with a READ_C request held: ignored during RUN, taken the cycle IDLE returns.
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(negedge clk);
        cmd_op = 2'b11;
        for (int c = 0; c < 4; c++) begin
            chk1("b2b_start", start_mat_mul, 1'b1);
            chk1("b2b_en_r_ignored", enable_reading_from_mem, 1'b0);
            done_mat_mul = (c == 3);
            @(negedge clk);
        end
        done_mat_mul = 1'b0;
        chk1("b2b_idle_ready", cmd_ready, 1'b1);
        chk1("b2b_start_low", start_mat_mul, 1'b0);
        salt = $urandom;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk1("b2b_no_dead_cycle", enable_reading_from_mem, 1'b1);
        read_check();

        foreach (rv[i]) begin
            issue_cmd(2'b10);
            drop  = -1;
            agree = 1'b1;
            for (int c = 0; c < 1200; c++) begin
                if (!start_mat_mul) begin
                    drop = c;
                    break;
                end
                if (we_c !== start_mat_mul) agree = 1'b0;
                done_mat_mul = (c == rv[i].done_at);
                @(negedge clk);
            end
            done_mat_mul = 1'b0;
            chki("run_drop_cycle", drop, rv[i].exp_drop);
            chk1("run_we_c_tracks", agree, 1'b1);
            chk1("run_we_c_low", we_c, 1'b0);
            chk1("run_err", err_timeout, rv[i].exp_err);
            chk1("run_busy_low", busy, 1'b0);
            chk1("run_ready", cmd_ready, 1'b1);
        end

        run_load(1'b1, 2, -1, pulses);
        chki("sticky_load_pulses", pulses, NR);
        chk1("err_sticky", err_timeout, 1'b1);

        run_load(1'b0, 0, 10, pulses);
        chk1("err_cleared_by_reset", err_timeout, 1'b0);
        run_load(1'b0, 0, -1, pulses);
        chki("restart_pulses", pulses, NR);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/matmul_host_ctrl.md
MATMUL_HOST_CTRL -- requirements
Module: matmul_host_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 7, BRAM address width.
REQ-002 SHALL have parameter DWIDTH, default 8, element width.
REQ-003 SHALL have parameter MAT_MUL_SIZE, default 16, elements per BRAM row.
REQ-004 SHALL have parameter NUM_ROWS, default 32, rows per load/read pass (1..2^AWIDTH).
REQ-005 SHALL have parameter WR_ALIGN, default 2, cycles from addr_pi to data_pi/we.
REQ-006 SHALL have parameter RD_LAT, default 4, cycles from addr_pi to data_from_out_mat.
REQ-007 SHALL have parameter RUN_TIMEOUT, default 1023, cycle limit for done_mat_mul.
REQ-008 SHALL have ports: clk in 1, the single clock; reset in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: cmd_valid in 1; cmd_op in 2 (00 LOAD_A, 01 LOAD_B, 10 RUN, 11 READ_C); cmd_ready out 1.
REQ-010 SHALL have ports: wr_valid in 1; wr_data in MAT_MUL_SIZE*DWIDTH; wr_ready out 1.
REQ-011 SHALL have ports: rd_valid out 1; rd_data out MAT_MUL_SIZE*DWIDTH; busy out 1; err_timeout out 1.
REQ-012 SHALL have datapath ports: enable_writing_to_mem, enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul out 1 each; addr_pi out AWIDTH; data_pi out MAT_MUL_SIZE*DWIDTH; done_mat_mul in 1; data_from_out_mat in MAT_MUL_SIZE*DWIDTH.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, LOAD_DRAIN, RUN, READ, READ_DRAIN.
REQ-014 cmd_ready SHALL be 1 only in IDLE; command accepted on cmd_valid&cmd_ready; op latched.
REQ-015 LOAD (LOAD_A/LOAD_B): enable_writing_to_mem=1; wr_ready=1; each wr_valid&wr_ready beat drives addr_pi=row counter, increments it.
REQ-016 Each beat's wr_data SHALL appear on data_pi with we_a (LOAD_A) or we_b (LOAD_B) exactly WR_ALIGN cycles after its addr_pi; we low on gaps.
REQ-017 After beat NUM_ROWS-1, SHALL enter LOAD_DRAIN, hold enable_writing_to_mem WR_ALIGN cycles, then IDLE.
REQ-018 RUN: start_mat_mul=1 and we_c=1 from entry until done_mat_mul sampled 1, then both 0 next cycle, IDLE.
REQ-019 RUN counter SHALL count cycles; on reaching RUN_TIMEOUT without done_mat_mul, err_timeout=1 (sticky), start_mat_mul/we_c drop, IDLE.
REQ-020 READ: enable_reading_from_mem=1; addr_pi steps 0..NUM_ROWS-1, one per cycle, no backpressure.
REQ-021 rd_valid SHALL pulse and rd_data=data_from_out_mat exactly RD_LAT cycles after each read address, in address order; exactly NUM_ROWS beats.
REQ-022 READ_DRAIN SHALL hold enable_reading_from_mem until last beat returned, then IDLE.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 Row counter SHALL be ceil(log2(NUM_ROWS+1)) bits, no wrap past NUM_ROWS-1; addr_pi zero-extended.
REQ-025 cmd_valid outside IDLE SHALL be ignored; wr_valid outside LOAD SHALL be ignored.
REQ-026 A new command accepted in the cycle IDLE is re-entered SHALL start the next cycle (no dead cycle).
REQ-027 err_timeout SHALL clear only on reset.

Reset
REQ-028 On reset low, asynchronously: state IDLE, counters 0, delay pipes cleared.
REQ-029 Reset values: cmd_ready 1 after release, all other outputs 0.
REQ-030 Reset mid-operation SHALL abort with no further we_a/we_b/we_c/rd_valid pulses.

Structure
REQ-031 cmd_op encodings and FSM state encodings SHALL be in shared package matmul_ctrl_pkg.
REQ-032 One sub-module, valid_delay_line (parameterised depth, valid+data), SHALL implement both WR_ALIGN and RD_LAT pipes.

Verification
REQ-033 LOAD_A, 32 beats wr_data=row index, continuous -> we_a 32 pulses, data_pi=k two cycles after addr_pi=k, then IDLE.
REQ-034 LOAD_B with wr_valid toggling every other cycle -> 32 we_b pulses, addresses 0..31 without gaps or repeats.
REQ-035 RUN, done_mat_mul asserted at cycle 100 -> start_mat_mul/we_c high cycles 0..100, low at 101, err_timeout 0.
REQ-036 RUN, done_mat_mul never asserted -> start_mat_mul drops at cycle 1023, err_timeout 1, busy 0.
REQ-037 READ_C, data_from_out_mat=f(addr) model -> 32 rd_valid beats, beat k at addr k+4 cycles, rd_data=f(k).
REQ-038 Reset low at LOAD beat 10 -> outputs 0 immediately, no further we_a, next LOAD_A restarts at address 0.
